serial_output_tx: RTL and testbench
===================================

# serial_output_tx

Parallel-to-serial output transmitter for the stereo datapath, the transmit-side counterpart of the frame-synchronised serial input path. It accepts one left/right pair of filter results per load pulse and shifts both words out MSB-first on OutputL/OutputR, with OutReady framing every valid bit. It sits in the SCLK domain between the filter engine and the chip output pins.

## Interface
- WIDTH, 40, bits per output word; legal range ≥ 2.
- SCLK  input  1  system clock; every state change occurs on its rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- load  input  1  single-cycle request to transmit dataL/dataR; sampled on the SCLK rising edge.
- dataL  input  WIDTH  left-channel word, captured only on an accepted load.
- dataR  input  WIDTH  right-channel word, captured only on an accepted load.
- OutputL  output  1  left serial data, MSB first, registered.
- OutputR  output  1  right serial data, MSB first, registered.
- OutReady  output  1  high while OutputL/OutputR carry valid bits, registered.
- busy  output  1  high while a word is being transmitted (state SHIFT).
- done  output  1  one-cycle pulse after the last bit of each word.
- overrun  output  1  sticky flag: a load was rejected; cleared only by reset.

## Operation
- Two states:
  - IDLE: shift registers hold don't-care data; OutputL = OutputR = OutReady = 0.
  - SHIFT: shifting a word.
- Bit counter width is $clog2(WIDTH). It counts 0 … WIDTH-1 and does not wrap past WIDTH-1.
- Load acceptance:
  - A load is accepted when state = IDLE.
  - A load is also accepted when state = SHIFT and the bit counter = WIDTH-1 (the last bit is on the pins). This permits gapless streaming.
- On accept:
  - shiftL ← dataL and shiftR ← dataR.
  - Bit counter ← 0.
  - State ← SHIFT.
  - OutputL ← dataL[WIDTH-1], OutputR ← dataR[WIDTH-1], OutReady ← 1.
- In SHIFT with counter < WIDTH-1:
  - The counter increments.
  - Both shift registers shift left by one.
  - The outputs take the next lower bit.
- In SHIFT with counter = WIDTH-1 and no accepted load:
  - State ← IDLE.
  - OutReady ← 0, OutputL ← 0, OutputR ← 0.
- done asserts for exactly one cycle following the edge that ends a word (counter = WIDTH-1). This holds whether or not a new load is accepted on that edge.
- Rejected load (state = SHIFT and counter ≠ WIDTH-1):
  - dataL/dataR are ignored.
  - The current word continues unaffected.
  - overrun ← 1 and stays set.
- Bits are transmitted verbatim, with no sign handling. The left and right channels are always bit-aligned.

## Timing
- Reset (asynchronous, immediate):
  - OutputL = OutputR = OutReady = busy = done = overrun = 0.
  - State = IDLE, counter = 0.
- Reset asserted mid-word aborts the word at once; no partial bits resume after release.
- load is sampled at edge E0.
  - After E0: OutReady = 1, outputs = bit WIDTH-1.
  - After edge Ek (k = 0 … WIDTH-1): outputs = bit WIDTH-1-k.
  - After E(WIDTH): OutReady = 0 and done = 1 for one cycle, unless reloaded at E(WIDTH-1)+1.
- Latency from load edge to MSB on the pins: 0 cycles after the edge (registered output). A word occupies exactly WIDTH SCLK cycles.
- Back-to-back: a load at the edge where the counter = WIDTH-1 gives the new MSB immediately after the old LSB. OutReady stays high continuously, done pulses once, and there is no overrun.
- busy equals (state = SHIFT); it is high for exactly the cycles in which OutReady is high.
- A load held high for several cycles is treated as one accept followed by rejects, so overrun sets.

## Test plan
- Single word, WIDTH=40: dataL=40'h80_0000_0001, dataR=40'h55_5555_5555, one load pulse → OutReady high for exactly 40 cycles; OutputL=1, 0×38, 1; OutputR alternates 0,1,…; done pulses once after bit 0; overrun=0.
- Back-to-back: second load (dataL=40'hFF_FFFF_FFFF) at the edge where the counter = 39 → 80 contiguous OutReady cycles; the LSB of word 1 is followed directly by a 1; done pulses twice, 40 cycles apart.
- Overrun: load at bit 10 of a word in progress → the transmitted word is unchanged; overrun=1 from the next cycle and remains 1 through idle and later words until reset_n=0.
- Reset mid-word: reset_n=0 at bit 20 → all outputs 0 immediately; after release, outputs stay 0 until the next load, and a new word transmits correctly from the MSB.
- Idle and boundary: no load for 100 cycles → OutputL=OutputR=OutReady=busy=0. With WIDTH=2 and data 2'b10/2'b01 → OutputL 1,0 and OutputR 0,1 over 2 cycles, done 1 cycle later.
- Held load: load high for 3 cycles → one 40-bit word is transmitted and overrun=1.

Source files
------------

// File: rtl/serial_output_tx.sv
// Stereo parallel-to-serial transmitter: shifts a left/right word pair out MSB-first
// on OutputL/OutputR, framed by OutReady, with gapless reload on the last bit.
`timescale 1ns/1ps
module serial_output_tx #(
  parameter int unsigned WIDTH = 40
) (
  input  logic             SCLK,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] dataL,
  input  logic [WIDTH-1:0] dataR,
  output logic             OutputL,
  output logic             OutputR,
  output logic             OutReady,
  output logic             busy,
  output logic             done,
  output logic             overrun
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam int unsigned SH_W  = WIDTH - 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  // Shift registers hold only the bits not yet placed on the pins.
  logic [SH_W-1:0]   shift_l_q;
  logic [SH_W-1:0]   shift_l_d;
  logic [SH_W-1:0]   shift_r_q;
  logic [SH_W-1:0]   shift_r_d;
  logic              out_l_d;
  logic              out_r_d;
  logic              rdy_d;
  logic              busy_d;
  logic              done_d;
  logic              ovr_d;

  logic              last_c;
  logic              accept_c;
  logic              reject_c;

  assign last_c   = (state_q == SHIFT) && (cnt_q == LAST_BIT);
  assign accept_c = load && ((state_q == IDLE) || last_c);
  assign reject_c = load && !accept_c;

  // State register
  always_ff @(posedge SCLK or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept_c) begin
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (last_c && !accept_c) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Next values for the datapath and the registered outputs
  always_comb begin
    cnt_d     = cnt_q;
    shift_l_d = shift_l_q;
    shift_r_d = shift_r_q;
    out_l_d   = 1'b0;
    out_r_d   = 1'b0;
    rdy_d     = 1'b0;
    busy_d    = (state_d == SHIFT);
    done_d    = last_c;
    ovr_d     = overrun | reject_c;
    if (accept_c) begin
      cnt_d     = '0;
      shift_l_d = dataL[SH_W-1:0];
      shift_r_d = dataR[SH_W-1:0];
      out_l_d   = dataL[WIDTH-1];
      out_r_d   = dataR[WIDTH-1];
      rdy_d     = 1'b1;
    end else if ((state_q == SHIFT) && !last_c) begin
      cnt_d     = cnt_q + CNT_W'(1);
      shift_l_d = shift_l_q << 1;
      shift_r_d = shift_r_q << 1;
      out_l_d   = shift_l_q[SH_W-1];
      out_r_d   = shift_r_q[SH_W-1];
      rdy_d     = 1'b1;
    end
  end

  // Datapath and output registers
  always_ff @(posedge SCLK or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q     <= '0;
      shift_l_q <= '0;
      shift_r_q <= '0;
      OutputL   <= 1'b0;
      OutputR   <= 1'b0;
      OutReady  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      shift_l_q <= shift_l_d;
      shift_r_q <= shift_r_d;
      OutputL   <= out_l_d;
      OutputR   <= out_r_d;
      OutReady  <= rdy_d;
      busy      <= busy_d;
      done      <= done_d;
      overrun   <= ovr_d;
    end
  end

endmodule

// File: tb/tb_serial_output_tx.sv
// Scoreboard bench for serial_output_tx: stimulus queues expected serial bits,
// a negedge monitor pops and compares them whenever OutReady is high.
`timescale 1ns/1ps
module tb_serial_output_tx;

  localparam int unsigned W = 40;

  logic         SCLK = 1'b0;
  logic         reset_n;
  logic         load;
  logic [W-1:0] dataL;
  logic [W-1:0] dataR;
  logic         OutputL, OutputR, OutReady, busy, done, overrun;

  logic         load2;
  logic [1:0]   dl2, dr2;
  logic         o2_l, o2_r, o2_rdy, o2_busy, o2_done, o2_ovr;

  always #5 SCLK = ~SCLK;

  serial_output_tx #(.WIDTH(W)) dut (
    .SCLK(SCLK), .reset_n(reset_n), .load(load), .dataL(dataL), .dataR(dataR),
    .OutputL(OutputL), .OutputR(OutputR), .OutReady(OutReady),
    .busy(busy), .done(done), .overrun(overrun)
  );

  serial_output_tx #(.WIDTH(2)) dut2 (
    .SCLK(SCLK), .reset_n(reset_n), .load(load2), .dataL(dl2), .dataR(dr2),
    .OutputL(o2_l), .OutputR(o2_r), .OutReady(o2_rdy),
    .busy(o2_busy), .done(o2_done), .overrun(o2_ovr)
  );

  typedef struct packed {
    logic l;
    logic r;
    logic last;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  logic prev_rdy = 1'b0;
  logic done_exp = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic push_word(input logic [W-1:0] l, input logic [W-1:0] r);
    for (int i = W - 1; i >= 0; i--) begin
      exp_q.push_back('{l: l[i], r: r[i], last: (i == 0)});
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge SCLK);
    #1;
  endtask

  // Monitor: compare serial bits and the done pulse against the scoreboard
  always @(negedge SCLK) begin
    if (!reset_n) begin
      prev_rdy = 1'b0;
      done_exp = 1'b0;
    end else begin
      check("done", 64'(done), 64'(done_exp));
      done_exp = 1'b0;
      if (OutReady) begin
        if (exp_q.size() == 0) begin
          check("extra_bit", 64'(OutReady), 64'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check("OutputL", 64'(OutputL), 64'(mon_e.l));
          check("OutputR", 64'(OutputR), 64'(mon_e.r));
          done_exp = mon_e.last;
        end
      end else begin
        check("idle_out", 64'({OutputL, OutputR}), 64'd0);
        if (prev_rdy && exp_q.size() != 0) check("gap", 64'(OutReady), 64'd1);
      end
      prev_rdy = OutReady;
    end
  end

  initial begin
    reset_n = 1'b0;
    load    = 1'b0;
    dataL   = '0;
    dataR   = '0;
    load2   = 1'b0;
    dl2     = '0;
    dr2     = '0;
    #2;
    check("reset_state", 64'({OutputL, OutputR, OutReady, busy, done, overrun}), 64'd0);
    tick(2);
    reset_n = 1'b1;
    tick(2);

    // Single word
    dataL = 40'h80_0000_0001;
    dataR = 40'h55_5555_5555;
    load  = 1'b1;
    push_word(dataL, dataR);
    tick(1);
    load = 1'b0;
    check("first_busy_rdy", 64'({busy, OutReady, OutputL, OutputR}), 64'b1110);
    tick(W - 1);
    check("single_lsb", 64'({OutReady, OutputL, OutputR, done}), 64'b1110);
    tick(1);
    check("single_end", 64'({OutReady, busy, done, overrun}), 64'b0010);
    tick(1);
    check("single_done_pulse", 64'(done), 64'd0);
    tick(3);
    check("q_empty_1", 64'(exp_q.size()), 64'd0);

    // Back-to-back: reload while the LSB is on the pins
    dataL = 40'h12_3456_789A;
    dataR = 40'hA5_C3_3C_5A_96;
    load  = 1'b1;
    push_word(dataL, dataR);
    tick(1);
    load = 1'b0;
    tick(W - 1);
    dataL = 40'hFF_FFFF_FFFF;
    dataR = 40'h0F_F00F_F00F;
    load  = 1'b1;
    push_word(dataL, dataR);
    tick(1);
    load = 1'b0;
    check("b2b_seam", 64'({OutReady, busy, done, overrun, OutputL, OutputR}), 64'b111010);
    tick(W - 1);
    check("b2b_last", 64'({OutReady, done}), 64'b10);
    tick(1);
    check("b2b_end", 64'({OutReady, done, overrun}), 64'b010);
    tick(3);

    // Rejected load mid-word leaves the word intact and sets overrun
    dataL = 40'hC3_A596_0FF0;
    dataR = 40'h3C_5A69_F00F;
    load  = 1'b1;
    push_word(dataL, dataR);
    tick(1);
    load = 1'b0;
    tick(9);
    dataL = 40'h00_0000_0000;
    dataR = 40'hFF_FFFF_FFFF;
    load  = 1'b1;
    tick(1);
    load = 1'b0;
    check("overrun_set", 64'(overrun), 64'd1);
    tick(W - 10);
    check("overrun_word_end", 64'({done, OutReady, overrun}), 64'b101);
    tick(10);
    check("overrun_sticky_idle", 64'(overrun), 64'd1);

    // Reset in the middle of a word
    dataL = 40'hDE_ADBE_EF01;
    dataR = 40'h01_2345_6789;
    load  = 1'b1;
    push_word(dataL, dataR);
    tick(1);
    load = 1'b0;
    tick(19);
    check("overrun_sticky_word", 64'(overrun), 64'd1);
    reset_n = 1'b0;
    exp_q.delete();
    #1;
    check("reset_mid", 64'({OutputL, OutputR, OutReady, busy, done, overrun}), 64'd0);
    tick(2);
    reset_n = 1'b1;
    tick(5);
    check("post_reset_idle", 64'({OutputL, OutputR, OutReady, busy, done, overrun}), 64'd0);
    dataL = 40'hB7_1234_ABCD;
    dataR = 40'h4C_FEDC_5432;
    load  = 1'b1;
    push_word(dataL, dataR);
    tick(1);
    load = 1'b0;
    tick(W);
    check("post_reset_word", 64'({done, OutReady, overrun}), 64'b100);
    tick(2);

    // Load held for three cycles: one word plus rejects
    dataL = 40'h96_6996_6996;
    dataR = 40'h69_9669_9669;
    load  = 1'b1;
    push_word(dataL, dataR);
    tick(1);
    dataL = 40'h00_0000_0000;
    dataR = 40'h00_0000_0000;
    tick(2);
    load = 1'b0;
    check("held_overrun", 64'(overrun), 64'd1);
    tick(W - 2);
    check("held_end", 64'({done, OutReady}), 64'b10);

    // Long idle
    tick(100);
    check("idle_100", 64'({OutputL, OutputR, OutReady, busy}), 64'd0);

    // WIDTH=2 boundary instance
    dl2   = 2'b10;
    dr2   = 2'b01;
    load2 = 1'b1;
    tick(1);
    load2 = 1'b0;
    check("w2_bit1", 64'({o2_l, o2_r, o2_rdy, o2_busy, o2_done}), 64'b10110);
    tick(1);
    check("w2_bit0", 64'({o2_l, o2_r, o2_rdy, o2_busy, o2_done}), 64'b01110);
    tick(1);
    check("w2_done", 64'({o2_l, o2_r, o2_rdy, o2_busy, o2_done, o2_ovr}), 64'b000010);
    tick(1);
    check("w2_done_clear", 64'(o2_done), 64'd0);

    tick(3);
    check("q_empty_end", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
